// File: rtl/operand_fetch_pkg.sv
// Shared register-file definitions and the output-stage record used by the
// operand fetch stage and its scoreboard.
package operand_fetch_pkg;

    localparam int RegisterWidth        = 32;
    localparam int RegisterAddressWidth = 5;
    localparam int RegisterNum          = 32;

    typedef logic [RegisterWidth-1:0]        RegisterBus;
    typedef logic [RegisterAddressWidth-1:0] RegisterAddressBus;

    localparam RegisterBus ZeroWord    = '0;
    localparam logic       WriteEnable = 1'b1;
    localparam logic       ReadEnable  = 1'b1;

    // Everything the output stage holds for one accepted instruction.
    typedef struct packed {
        RegisterBus        op1;
        RegisterBus        op2;
        RegisterAddressBus rd;
        logic              write_rd;
    } stage_t;

    // Register 0 is hard-wired to zero, so it never carries a dependency.
    function automatic logic is_real_reg(input RegisterAddressBus address);
        return address != '0;
    endfunction

endpackage

// File: rtl/operand_fetch_reg_scoreboard.sv
// Per-register pending-write counters. Each counter tracks how many accepted
// instructions will still write that register. The module answers hazard
// queries for the instruction currently being decoded and folds in the
// register-file write (clear), new writers (increment) and flushed writers
// (decrement) every cycle.
module reg_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int SCORE_WIDTH = 2
) (
    input  logic              clock,
    input  logic              reset,

    input  RegisterAddressBus query_rs,
    input  logic              query_use_rs,
    input  RegisterAddressBus query_rt,
    input  logic              query_use_rt,
    input  RegisterAddressBus query_rd,
    input  logic              query_write_rd,
    output logic              rs_hazard,
    output logic              rt_hazard,
    output logic              rd_hazard,

    input  logic              clear_enable,
    input  RegisterAddressBus clear_address,
    input  logic              inc_enable,
    input  RegisterAddressBus inc_address,
    input  logic              dec_enable,
    input  RegisterAddressBus dec_address
);

    localparam logic [SCORE_WIDTH-1:0] MaxCount    = '1;
    localparam int                     MaxCountInt = (1 << SCORE_WIDTH) - 1;

    logic [SCORE_WIDTH-1:0] count      [RegisterNum];
    logic [SCORE_WIDTH-1:0] next_count [RegisterNum];
    logic [RegisterNum-1:0] clear_hit;
    logic [SCORE_WIDTH-1:0] rs_remaining;
    logic [SCORE_WIDTH-1:0] rt_remaining;

    // A write-back only retires a pending write if one is actually
    // outstanding; a write to an idle register (or to r0) is ignored.
    always_comb begin
        clear_hit = '0;
        for (int r = 1; r < RegisterNum; r++) begin
            clear_hit[r] = (clear_enable == WriteEnable)
                        && (clear_address == RegisterAddressBus'(r))
                        && (count[r] != '0);
        end
    end

    // Sources see the count as it will be after this cycle's write-back,
    // since the register file forwards same-cycle write data to its read
    // ports. A destination only blocks when its counter would overflow.
    always_comb begin
        rs_remaining = count[query_rs] - SCORE_WIDTH'(clear_hit[query_rs]);
        rt_remaining = count[query_rt] - SCORE_WIDTH'(clear_hit[query_rt]);
        rs_hazard    = query_use_rs && is_real_reg(query_rs) && (rs_remaining != '0);
        rt_hazard    = query_use_rt && is_real_reg(query_rt) && (rt_remaining != '0);
        rd_hazard    = query_write_rd && is_real_reg(query_rd)
                    && (count[query_rd] == MaxCount) && !clear_hit[query_rd];
    end

    // Net effect of increment, clear and flush-decrement on every register,
    // clamped to the counter range so simultaneous events combine cleanly.
    always_comb begin
        int sum;
        sum = 0;
        next_count[0] = '0;
        for (int r = 1; r < RegisterNum; r++) begin
            sum = int'(count[r]);
            if (inc_enable && (inc_address == RegisterAddressBus'(r))) begin
                sum = sum + 1;
            end
            if (clear_hit[r]) begin
                sum = sum - 1;
            end
            if (dec_enable && (dec_address == RegisterAddressBus'(r))) begin
                sum = sum - 1;
            end
            if (sum < 0) begin
                sum = 0;
            end
            if (sum > MaxCountInt) begin
                sum = MaxCountInt;
            end
            next_count[r] = SCORE_WIDTH'(sum);
        end
    end

    // Counter storage; reset forgets every outstanding write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < RegisterNum; r++) begin
                count[r] <= '0;
            end
        end else begin
            for (int r = 0; r < RegisterNum; r++) begin
                count[r] <= next_count[r];
            end
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads source registers for a decoded instruction,
// stalls it while a source still has an outstanding write or its
// destination counter is full, and presents the operands one cycle later
// in a single output register with a valid/ready handshake and flush.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int SCORE_WIDTH = 2
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              in_valid,
    output logic              in_ready,
    input  RegisterAddressBus in_rs,
    input  RegisterAddressBus in_rt,
    input  RegisterAddressBus in_rd,
    input  logic              in_use_rs,
    input  logic              in_use_rt,
    input  logic              in_write_rd,

    output logic              read_enable1,
    output logic              read_enable2,
    output RegisterAddressBus read_address1,
    output RegisterAddressBus read_address2,
    input  RegisterBus        read_data1,
    input  RegisterBus        read_data2,

    input  logic              wb_write_enable,
    input  RegisterAddressBus wb_write_address,

    input  logic              flush,

    output logic              out_valid,
    input  logic              out_ready,
    output RegisterBus        out_op1,
    output RegisterBus        out_op2,
    output RegisterAddressBus out_rd,
    output logic              out_write_rd
);

    stage_t out_stage;
    logic   rs_hazard;
    logic   rt_hazard;
    logic   rd_hazard;
    logic   slot_free;
    logic   accept;
    logic   inc_enable;
    logic   dec_enable;

    // Register-file read ports follow the decoded instruction directly.
    always_comb begin
        read_enable1  = (in_valid && in_use_rs) ? ReadEnable : ~ReadEnable;
        read_enable2  = (in_valid && in_use_rt) ? ReadEnable : ~ReadEnable;
        read_address1 = in_rs;
        read_address2 = in_rt;
    end

    // Acceptance: the output slot must be empty, draining or being flushed,
    // and the scoreboard must report no hazard. Nothing is taken in reset.
    always_comb begin
        slot_free  = !out_valid || out_ready || flush;
        accept     = in_valid && !reset && !rs_hazard && !rt_hazard
                  && !rd_hazard && slot_free;
        in_ready   = accept;
        inc_enable = accept && in_write_rd && is_real_reg(in_rd);
        dec_enable = flush && out_valid && out_stage.write_rd
                  && is_real_reg(out_stage.rd);
    end

    reg_scoreboard #(
        .SCORE_WIDTH (SCORE_WIDTH)
    ) u_scoreboard (
        .clock          (clock),
        .reset          (reset),
        .query_rs       (in_rs),
        .query_use_rs   (in_use_rs),
        .query_rt       (in_rt),
        .query_use_rt   (in_use_rt),
        .query_rd       (in_rd),
        .query_write_rd (in_write_rd),
        .rs_hazard      (rs_hazard),
        .rt_hazard      (rt_hazard),
        .rd_hazard      (rd_hazard),
        .clear_enable   (wb_write_enable),
        .clear_address  (wb_write_address),
        .inc_enable     (inc_enable),
        .inc_address    (in_rd),
        .dec_enable     (dec_enable),
        .dec_address    (out_stage.rd)
    );

    // Output register: capture on accept, drop valid when consumed or
    // flushed, otherwise hold everything stable for a stalled consumer.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid          <= 1'b0;
            out_stage.op1      <= ZeroWord;
            out_stage.op2      <= ZeroWord;
            out_stage.rd       <= '0;
            out_stage.write_rd <= 1'b0;
        end else if (accept) begin
            out_valid          <= 1'b1;
            out_stage.op1      <= in_use_rs ? read_data1 : ZeroWord;
            out_stage.op2      <= in_use_rt ? read_data2 : ZeroWord;
            out_stage.rd       <= in_rd;
            out_stage.write_rd <= in_write_rd;
        end else if (out_ready || flush) begin
            out_valid          <= 1'b0;
        end
    end

    // Expose the held output stage.
    always_comb begin
        out_op1      = out_stage.op1;
        out_op2      = out_stage.op2;
        out_rd       = out_stage.rd;
        out_write_rd = out_stage.write_rd;
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a register file with same-cycle write bypass,
// directed scenarios, then randomized traffic compared against a
// pending-write-count reference model.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    localparam int ScoreWidth = 2;
    localparam int MaxPend    = (1 << ScoreWidth) - 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    RegisterAddressBus in_rs;
    RegisterAddressBus in_rt;
    RegisterAddressBus in_rd;
    logic              in_use_rs;
    logic              in_use_rt;
    logic              in_write_rd;
    logic              read_enable1;
    logic              read_enable2;
    RegisterAddressBus read_address1;
    RegisterAddressBus read_address2;
    RegisterBus        read_data1;
    RegisterBus        read_data2;
    logic              wb_write_enable;
    RegisterAddressBus wb_write_address;
    RegisterBus        wb_write_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    RegisterBus        out_op1;
    RegisterBus        out_op2;
    RegisterAddressBus out_rd;
    logic              out_write_rd;

    RegisterBus regs [RegisterNum];

    int         pend [RegisterNum];
    bit         expOv;
    RegisterBus expOp1;
    RegisterBus expOp2;
    int         expRd;
    bit         expWrd;
    RegisterBus lastWbData;
    int         testsRun;
    int         testsFailed;

    always #5 clock = ~clock;

    // Register file behaviour: a write in flight is visible on the read port.
    assign read_data1 = (wb_write_enable && wb_write_address == read_address1 && wb_write_address != '0)
                        ? wb_write_data : regs[read_address1];
    assign read_data2 = (wb_write_enable && wb_write_address == read_address2 && wb_write_address != '0)
                        ? wb_write_data : regs[read_address2];

    operand_fetch #(
        .SCORE_WIDTH (ScoreWidth)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_rs            (in_rs),
        .in_rt            (in_rt),
        .in_rd            (in_rd),
        .in_use_rs        (in_use_rs),
        .in_use_rt        (in_use_rt),
        .in_write_rd      (in_write_rd),
        .read_enable1     (read_enable1),
        .read_enable2     (read_enable2),
        .read_address1    (read_address1),
        .read_address2    (read_address2),
        .read_data1       (read_data1),
        .read_data2       (read_data2),
        .wb_write_enable  (wb_write_enable),
        .wb_write_address (wb_write_address),
        .flush            (flush),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_op1          (out_op1),
        .out_op2          (out_op2),
        .out_rd           (out_rd),
        .out_write_rd     (out_write_rd)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Writes still outstanding on register r once this cycle's write-back lands.
    function automatic int pendAfter(input int r, input bit wbe, input int wba);
        int c;
        if (r == 0) return 0;
        c = pend[r];
        if (wbe && wba == r && c > 0) c--;
        return c;
    endfunction

    // Value a read of register r returns this cycle.
    function automatic RegisterBus valueOf(input int r, input bit wbe, input int wba, input RegisterBus wbd);
        if (r == 0) return ZeroWord;
        if (wbe && wba == r) return wbd;
        return regs[r];
    endfunction

    task automatic applyStimulus(input bit rst, input bit v, input int rs, input int rt, input int rd,
                                 input bit urs, input bit urt, input bit wrd,
                                 input bit wbe, input int wba, input bit fl, input bit ordy);
        bit         haz;
        bit         expReady;
        RegisterBus wbd;
        RegisterBus v1;
        RegisterBus v2;
        int         delta;
        wbd = $urandom;
        @(negedge clock);
        reset            = rst;
        in_valid         = v;
        in_rs            = RegisterAddressBus'(rs);
        in_rt            = RegisterAddressBus'(rt);
        in_rd            = RegisterAddressBus'(rd);
        in_use_rs        = urs;
        in_use_rt        = urt;
        in_write_rd      = wrd;
        wb_write_enable  = wbe;
        wb_write_address = RegisterAddressBus'(wba);
        wb_write_data    = wbd;
        lastWbData       = wbd;
        flush            = fl;
        out_ready        = ordy;
        #1;
        haz = (urs && pendAfter(rs, wbe, wba) > 0)
           || (urt && pendAfter(rt, wbe, wba) > 0)
           || (wrd && rd != 0 && pend[rd] == MaxPend && !(wbe && wba == rd));
        expReady = !rst && v && !haz && (!expOv || ordy || fl);
        checkOutput("in_ready", in_ready, expReady);
        checkOutput("read_enable1", read_enable1, v && urs);
        checkOutput("read_enable2", read_enable2, v && urt);
        checkOutput("read_address1", read_address1, rs);
        checkOutput("read_address2", read_address2, rt);
        v1 = urs ? valueOf(rs, wbe, wba, wbd) : ZeroWord;
        v2 = urt ? valueOf(rt, wbe, wba, wbd) : ZeroWord;
        @(posedge clock);
        #1;
        if (rst) begin
            for (int r = 0; r < RegisterNum; r++) pend[r] = 0;
            expOv  = 0;
            expOp1 = ZeroWord;
            expOp2 = ZeroWord;
            expRd  = 0;
            expWrd = 0;
        end else begin
            for (int r = 1; r < RegisterNum; r++) begin
                delta = 0;
                if (expReady && wrd && rd == r) delta++;
                if (wbe && wba == r && pend[r] > 0) delta--;
                if (fl && expOv && expWrd && expRd == r) delta--;
                pend[r] = (pend[r] + delta < 0) ? 0 : pend[r] + delta;
            end
            if (expReady) begin
                expOv  = 1;
                expOp1 = v1;
                expOp2 = v2;
                expRd  = rd;
                expWrd = wrd;
            end else if (ordy || fl) begin
                expOv = 0;
            end
        end
        if (wbe && wba != 0) regs[wba] = wbd;
        checkOutput("out_valid", out_valid, expOv);
        checkOutput("out_op1", out_op1, expOp1);
        checkOutput("out_op2", out_op2, expOp2);
        checkOutput("out_rd", out_rd, expRd);
        checkOutput("out_write_rd", out_write_rd, expWrd);
    endtask

    task automatic idle(input bit ordy);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ordy);
    endtask

    initial begin
        int  start;
        int  cand;
        bit  rst;
        bit  v;
        bit  wbe;
        int  wba;
        testsRun         = 0;
        testsFailed      = 0;
        reset            = 1'b1;
        in_valid         = 1'b0;
        in_rs            = '0;
        in_rt            = '0;
        in_rd            = '0;
        in_use_rs        = 1'b0;
        in_use_rt        = 1'b0;
        in_write_rd      = 1'b0;
        wb_write_enable  = 1'b0;
        wb_write_address = '0;
        wb_write_data    = '0;
        flush            = 1'b0;
        out_ready        = 1'b1;
        for (int r = 0; r < RegisterNum; r++) begin
            regs[r] = (r == 0) ? ZeroWord : RegisterBus'($urandom);
            pend[r] = 0;
        end
        regs[3] = 32'h1234;
        expOv  = 0;
        expOp1 = ZeroWord;
        expOp2 = ZeroWord;
        expRd  = 0;
        expWrd = 0;

        // Reset with a valid instruction present: nothing may be accepted.
        repeat (2) applyStimulus(1, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 1);

        // Simple source read of r3.
        applyStimulus(0, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        checkOutput("r3_operand", out_op1, 32'h1234);

        // Read-after-write on r5 resolved by write-back bypass.
        applyStimulus(0, 1, 0, 0, 5, 0, 0, 1, 0, 0, 0, 1);
        repeat (3) applyStimulus(0, 1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 5, 0, 0, 1, 0, 0, 1, 5, 0, 1);
        checkOutput("r5_bypass", out_op1, lastWbData);

        // Saturating r7 with three writers; a fourth waits for a write-back.
        repeat (3) applyStimulus(0, 1, 0, 0, 7, 0, 0, 1, 0, 0, 0, 1);
        repeat (2) applyStimulus(0, 1, 0, 0, 7, 0, 0, 1, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 7, 0, 0, 1, 1, 7, 0, 1);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1);
        applyStimulus(0, 1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 1);

        // Both sources r0.
        applyStimulus(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
        checkOutput("r0_op1", out_op1, 32'h0);
        checkOutput("r0_op2", out_op2, 32'h0);

        // Stalled consumer, then flush of the r9 writer.
        idle(1);
        applyStimulus(0, 1, 0, 0, 9, 0, 0, 1, 0, 0, 0, 0);
        repeat (4) applyStimulus(0, 1, 1, 2, 3, 1, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 1, 9, 0, 0, 1, 0, 0, 0, 0, 0, 1);

        // Reset while r10 is pending and the output is held.
        idle(1);
        applyStimulus(0, 1, 0, 0, 10, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 10, 0, 0, 1, 0, 0, 0, 0, 0, 1);

        // Randomized traffic on a narrow register window to force collisions.
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            v   = ($urandom_range(0, 99) < 80);
            wbe = ($urandom_range(0, 99) < 45);
            wba = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                start = $urandom_range(1, 31);
                for (int k = 0; k < 31; k++) begin
                    cand = 1 + ((start - 1 + k) % 31);
                    if (pend[cand] > 0) begin
                        wba = cand;
                        break;
                    end
                end
            end
            applyStimulus(rst, v, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          wbe, wba, ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 70));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
